rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: DW, default 32, write-data width.
REQ-002 Parameter: AW, default 5, register-address width.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: hold  input  1  when 1, no grant is issued this cycle.
REQ-006 Port: alu_valid  input  1  ALU writeback request.
REQ-007 Port: alu_rd  input  AW  ALU destination register.
REQ-008 Port: alu_data  input  DW  ALU result.
REQ-009 Port: alu_ready  output  1  ALU request granted this cycle.
REQ-010 Port: ld_valid  input  1  load-unit writeback request.
REQ-011 Port: ld_rd  input  AW  load destination register.
REQ-012 Port: ld_data  input  DW  load data.
REQ-013 Port: ld_ready  output  1  load request granted this cycle.
REQ-014 Port: rf_we  output  1  registered write-enable to the register file.
REQ-015 Port: rf_rd  output  AW  registered write address.
REQ-016 Port: rf_wdata  output  DW  registered write data.
REQ-017 Port: starve_flag  output  1  a valid requester has waited 4 or more consecutive cycles.

Function
REQ-018 A transfer occurs on a requester when its valid and ready are both 1 in the same cycle.
REQ-019 alu_ready and ld_ready are combinational and never both 1 in the same cycle.
REQ-020 Both ready outputs are 0 whenever rst=1 or hold=1.
REQ-021 With exactly one valid requester and hold=0, that requester gets ready=1.
REQ-022 With both valid and hold=0, the requester not granted most recently gets ready=1 (round-robin).
REQ-023 The last-grant pointer updates only on a transfer; it is unchanged by hold, idle cycles or a valid drop.
REQ-024 Latency: a transfer in cycle N drives rf_we/rf_rd/rf_wdata with that request's rd/data in cycle N+1.
REQ-025 rf_we is 1 for exactly one cycle per transfer; it is 0 in any cycle following a non-transfer cycle.
REQ-026 A transfer with rd=0 completes (ready=1) but produces rf_we=0 in cycle N+1 (x0 write suppressed).
REQ-027 rf_rd and rf_wdata hold their previous values when no transfer occurs.
REQ-028 Both valid with equal rd: the round-robin winner writes first, the other in a later cycle; the later write is final.
REQ-029 Per-requester wait counters (3 bits, saturating at 7) increment each cycle that requester is valid without transfer and clear on its transfer or when valid=0.
REQ-030 starve_flag is registered and equals 1 when either wait counter is 4 or more.
REQ-031 Requester inputs may change while not ready; only values present at the transfer cycle are used.

Reset
REQ-032 When rst=1 at a clock edge: rf_we=0, rf_rd=0, rf_wdata=0, wait counters=0, starve_flag=0, and the pointer marks the load unit as last granted (the ALU wins the first tie).
REQ-033 Requests asserted during rst are neither granted nor written, and no rf_we pulse follows reset.

Structure
REQ-034 A shared package holds the requester index constants (REQ_ALU=0, REQ_LD=1), AW/DW defaults and the starvation threshold (4).
REQ-035 One sub-module, rr_arbiter2, implements the 2-way round-robin grant and pointer; the top adds output registers, x0 suppression and starvation counters.

Verification
REQ-036 Only alu_valid=1, rd=5, data=0x1234 -> alu_ready=1 in cycle N; rf_we=1, rf_rd=5, rf_wdata=0x00001234 in cycle N+1.
REQ-037 Both valid for 4 cycles after reset, rd=1 and rd=2 -> grants ALU, LD, ALU, LD; rf_rd sequence is 1,2,1,2.
REQ-038 ld_valid=1, rd=0, data=0xFFFFFFFF -> ld_ready=1; rf_we stays 0; rf_rd and rf_wdata stay unchanged.
REQ-039 hold=1 for 5 cycles with alu_valid=1 -> readies 0; starve_flag=1 from the cycle after the 4th waiting cycle; clears after the transfer once hold=0.
REQ-040 Both valid with rd=7 (ALU data 0xA, LD data 0xB), round-robin state after reset -> writes 0xA then 0xB; final write is 0xB.
REQ-041 rst=1 in the cycle of a transfer -> no ready and no rf_we pulse follow; pointer reset so the ALU wins the next tie.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rf_write_arbiter_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    // Requester index; also used as the "last granted" pointer value.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_e;

    localparam logic [2:0] STARVE_THRESH = 3'd4;
    localparam logic [2:0] WAIT_MAX      = 3'd7;

    // Next wait count: clears on transfer or when idle, otherwise saturating increment.
    function automatic logic [2:0] wait_next(input logic [2:0] cur,
                                             input logic       vld,
                                             input logic       xfer);
        logic [2:0] nxt;
        nxt = 3'd0;
        if (vld && !xfer) begin
            nxt = (cur == WAIT_MAX) ? WAIT_MAX : cur + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a last-grant pointer.
// Latency: grant is combinational from req/en; pointer updates on the next edge.
// Backpressure: en=0 suppresses all grants and freezes the pointer.
module rr_arbiter2
    import rf_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_e last_q;
    req_e last_d;

    // Grant the lone requester, or on a tie the one not granted most recently.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req[REQ_ALU] && req[REQ_LD]) begin
                if (last_q == REQ_LD) begin
                    gnt[REQ_ALU] = 1'b1;
                end else begin
                    gnt[REQ_LD] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
        if (gnt[REQ_ALU]) begin
            last_d = REQ_ALU;
        end else if (gnt[REQ_LD]) begin
            last_d = REQ_LD;
        end
    end

    // Pointer register; reset marks the load unit as last granted so the ALU wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_LD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port.
// Latency: ready is combinational in cycle N; rf_we/rf_rd/rf_wdata are registered in N+1.
// Backpressure: hold or rst forces both readies low; losers keep valid asserted and retry.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_rd,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_wdata,
    output logic          starve_flag
);

    logic [1:0]    gnt;
    logic          alu_xfer;
    logic          ld_xfer;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_data;

    logic          rf_we_q,    rf_we_d;
    logic [AW-1:0] rf_rd_q,    rf_rd_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic [2:0]    alu_wait_q, alu_wait_d;
    logic [2:0]    ld_wait_q,  ld_wait_d;
    logic          starve_q,   starve_d;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (!rst && !hold),
        .req ({ld_valid, alu_valid}),
        .gnt (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign ld_ready  = gnt[REQ_LD];
    assign alu_xfer  = alu_valid && alu_ready;
    assign ld_xfer   = ld_valid && ld_ready;

    // Capture the winning request; writes to x0 complete but never raise rf_we or disturb rd/wdata.
    always_comb begin
        sel_rd     = alu_rd;
        sel_data   = alu_data;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (ld_xfer) begin
            sel_rd   = ld_rd;
            sel_data = ld_data;
        end
        if ((alu_xfer || ld_xfer) && (sel_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = sel_rd;
            rf_wdata_d = sel_data;
        end
    end

    // Wait counters and starvation flag; the flag tracks the counters' next values so it rises with them.
    always_comb begin
        alu_wait_d = wait_next(alu_wait_q, alu_valid, alu_xfer);
        ld_wait_d  = wait_next(ld_wait_q, ld_valid, ld_xfer);
        starve_d   = (alu_wait_d >= STARVE_THRESH) || (ld_wait_d >= STARVE_THRESH);
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            alu_wait_q <= 3'd0;
            ld_wait_q  <= 3'd0;
            starve_q   <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            alu_wait_q <= alu_wait_d;
            ld_wait_q  <= ld_wait_d;
            starve_q   <= starve_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_rd       = rf_rd_q;
    assign rf_wdata    = rf_wdata_q;
    assign starve_flag = starve_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: model predicts grants, writes and starvation.
// Latency: expected writes are due one cycle after the modelled transfer.
// Backpressure: random hold bursts and resets exercise stalls and starvation.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        starve_flag;

    rf_write_arbiter #(.DW(32), .AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .starve_flag (starve_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: who should be granted, what gets written, who is starving.
    int last_win = 1;   // 0 = ALU, 1 = load unit
    int wait_alu = 0;
    int wait_ld  = 0;
    bit exp_starve = 1'b0;

    initial begin
        forever begin
            int g;
            wr_t e;
            @(negedge clk);
            chk("starve_flag", {63'd0, starve_flag}, {63'd0, exp_starve});
            g = -1;
            if (!rst && !hold) begin
                if (alu_valid && ld_valid) g = 1 - last_win;
                else if (alu_valid)        g = 0;
                else if (ld_valid)         g = 1;
            end
            chk("alu_ready", {63'd0, alu_ready}, {63'd0, (g == 0)});
            chk("ld_ready",  {63'd0, ld_ready},  {63'd0, (g == 1)});
            if (rst) begin
                last_win   = 1;
                wait_alu   = 0;
                wait_ld    = 0;
                exp_starve = 1'b0;
            end else begin
                if (g >= 0) begin
                    last_win = g;
                    e.stamp  = cyc;
                    e.rd     = (g == 0) ? alu_rd : ld_rd;
                    e.data   = (g == 0) ? alu_data : ld_data;
                    if (e.rd != 5'd0) sb.push_back(e);
                end
                wait_alu   = (alu_valid && g != 0) ? wait_alu + 1 : 0;
                wait_ld    = (ld_valid && g != 1) ? wait_ld + 1 : 0;
                exp_starve = (wait_alu >= 4) || (wait_ld >= 4);
            end
        end
    end

    // Monitor: consumes expected writes whenever the DUT presents one.
    logic [4:0]  held_rd   = '0;
    logic [31:0] held_data = '0;

    initial begin
        forever begin
            wr_t e;
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (sb.size() == 0 || sb[0].stamp >= cyc) begin
                    chk("spurious_we", {63'd0, rf_we}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rf_rd",    {59'd0, rf_rd},    {59'd0, e.rd});
                    chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.data});
                    held_rd   = e.rd;
                    held_data = e.data;
                end
            end else begin
                chk("rf_rd_hold",    {59'd0, rf_rd},    {59'd0, held_rd});
                chk("rf_wdata_hold", {32'd0, rf_wdata}, {32'd0, held_data});
                if (sb.size() > 0 && sb[0].stamp < cyc) begin
                    chk("missing_we", {63'd0, rf_we}, 64'd1);
                    void'(sb.pop_front());
                end
            end
            if (rst) begin
                held_rd   = '0;
                held_data = '0;
            end
        end
    end

    task automatic drive(input logic r, input logic h,
                         input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        @(posedge clk);
        #1;
        rst = r; hold = h;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid  = lv; ld_rd  = lrd; ld_data  = ldat;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int hold_left;
        // Reset with requests pending: nothing may be granted or written.
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        idle(2);
        // Single ALU request.
        drive(0, 0, 1, 5'd5, 32'h1234, 0, 0, 0);
        idle(2);
        // Tie for four cycles straight after reset.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i);
        idle(2);
        // Load to x0 completes silently.
        drive(0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        idle(2);
        // Hold for five cycles with the ALU waiting, then release.
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 5'd9, 32'h99, 0, 0, 0);
        drive(0, 0, 1, 5'd9, 32'h99, 0, 0, 0);
        idle(3);
        // Same destination from both sides after reset.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 5'd7, 32'hA, 1, 5'd7, 32'hB);
        drive(0, 0, 0, 0, 0, 1, 5'd7, 32'hB);
        idle(2);
        // Reset in a would-be transfer cycle, then a tie the ALU must win.
        drive(0, 0, 0, 0, 0, 1, 5'd6, 32'h66);
        drive(1, 0, 1, 5'd8, 32'h88, 0, 0, 0);
        drive(0, 0, 1, 5'd8, 32'h88, 1, 5'd6, 32'h66);
        idle(2);
        // Random traffic with hold bursts and occasional resets.
        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            logic h;
            h = 1'b0;
            if (hold_left > 0) begin
                h = 1'b1;
                hold_left--;
            end else if ($urandom_range(0, 15) == 0) begin
                hold_left = $urandom_range(1, 7);
            end
            drive($urandom_range(0, 99) == 0, h,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(4);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
